display_scanner: RTL and testbench

Multiplexed 4-digit seven-segment driver for the stopwatch. It reads the packed BCD MM:SS `number` bus written by the counter module and scans one digit at a time onto shared segment lines. Each digit gets a fixed dwell period with a ghost-suppression blanking interval at its start. The value is snapshotted once per frame, so a count update never tears across digits.

---
 rtl/display_scanner_if.sv | 21 ++
 rtl/display_scanner.sv | 81 ++++++++
 tb/tb_display_scanner.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/display_scanner_if.sv
// Signal bundle between the stopwatch counter side and the seven-segment scanner.
// The master drives the BCD value and display controls; the slave drives the pins.
interface display_scanner_if;
   logic [15:0] number;
   logic        dp_enable;
   logic        blank_leading_zero;
   logic [6:0]  segments;
   logic        dp;
   logic [3:0]  digit_select;
   logic        frame_done;

   modport master (
      output number, dp_enable, blank_leading_zero,
      input  segments, dp, digit_select, frame_done
   );

   modport slave (
      input  number, dp_enable, blank_leading_zero,
      output segments, dp, digit_select, frame_done
   );
endinterface

// File: rtl/display_scanner.sv
// Multiplexed 4-digit seven-segment scanner for a packed BCD MM:SS value.
// The value is snapshotted once per frame so a count update never tears across digits.
module display_scanner #(
   parameter int unsigned DIGIT_PERIOD_CYCLES = 100_000,
   parameter int unsigned BLANK_CYCLES        = 16,
   parameter bit          ACTIVE_LOW          = 1'b1
) (
   input logic              clk,
   input logic              rst,
   display_scanner_if.slave bus
);
   localparam int unsigned    PW      = $clog2(DIGIT_PERIOD_CYCLES);
   localparam logic [PW-1:0]  P_MAX   = PW'(DIGIT_PERIOD_CYCLES - 1);
   localparam logic [PW-1:0]  P_BLANK = PW'(BLANK_CYCLES);

   logic [PW-1:0] p;
   logic [1:0]    i;
   logic [15:0]   s;

   logic          p_wrap;
   logic          i_wrap;
   logic          blanking;
   logic [3:0]    d;
   logic [6:0]    glyph;
   logic [6:0]    seg_lit;
   logic [3:0]    sel_lit;
   logic          dp_lit;

   always_comb begin
      p_wrap   = (p == P_MAX);
      i_wrap   = p_wrap && (i == 2'd3);
      blanking = (p < P_BLANK);
      d        = s[{i, 2'b00} +: 4];

      unique case (d)
         4'd0:    glyph = 7'h3F;
         4'd1:    glyph = 7'h06;
         4'd2:    glyph = 7'h5B;
         4'd3:    glyph = 7'h4F;
         4'd4:    glyph = 7'h66;
         4'd5:    glyph = 7'h6D;
         4'd6:    glyph = 7'h7D;
         4'd7:    glyph = 7'h07;
         4'd8:    glyph = 7'h7F;
         4'd9:    glyph = 7'h6F;
         default: glyph = 7'h40;
      endcase

      seg_lit = glyph;
      if (bus.blank_leading_zero && (i == 2'd3) && (d == 4'd0))
         seg_lit = '0;
      if (blanking)
         seg_lit = '0;

      // Ghost suppression: every digit is off at the start of each dwell.
      sel_lit = blanking ? 4'b0000 : (4'b0001 << i);
      dp_lit  = !blanking && (i == 2'd2) && bus.dp_enable;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p                <= '0;
         i                <= '0;
         s                <= '0;
         bus.frame_done   <= 1'b0;
         bus.segments     <= {7{ACTIVE_LOW}};
         bus.dp           <= ACTIVE_LOW;
         bus.digit_select <= {4{ACTIVE_LOW}};
      end else begin
         p <= p_wrap ? '0 : p + 1'b1;
         if (p_wrap)
            i <= i + 2'd1;
         if (i_wrap)
            s <= bus.number;
         bus.frame_done   <= i_wrap;
         bus.segments     <= seg_lit ^ {7{ACTIVE_LOW}};
         bus.dp           <= dp_lit ^ ACTIVE_LOW;
         bus.digit_select <= sel_lit ^ {4{ACTIVE_LOW}};
      end
   end
endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: expected dwells are queued per frame and a
// monitor pops one entry at each blank-to-active digit transition.
module tb_display_scanner;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   display_scanner_if bus ();

   display_scanner #(
      .DIGIT_PERIOD_CYCLES(8),
      .BLANK_CYCLES(2),
      .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0] sel;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input logic [3:0] sel, input logic [6:0] seg, input logic dp);
      exp_t e;
      e.sel = sel;
      e.seg = seg;
      e.dp  = dp;
      exp_q.push_back(e);
   endtask

   task automatic wait_frame(output int at);
      bit got = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
         @(posedge clk);
         #1;
         if (bus.frame_done) got = 1'b1;
      end
      at = cyc;
      if (!got) begin
         total++;
         bad++;
         $display("FAIL frame_wait: no frame_done within 100 cycles (cycle %0d)", cyc);
      end
   endtask

   task automatic check_reset_pins(input string tag);
      check({tag, "_segments"}, {25'd0, bus.segments}, 32'h7F);
      check({tag, "_dp"}, {31'd0, bus.dp}, 32'h1);
      check({tag, "_digit_select"}, {28'd0, bus.digit_select}, 32'hF);
      check({tag, "_frame_done"}, {31'd0, bus.frame_done}, 32'h0);
   endtask

   // Monitor: one-hot/blank invariants every cycle, dwell contents and length per digit.
   logic [3:0] prev_sel = 4'hF;
   bit         tracking = 1'b0;
   int         dwell_len = 0;
   exp_t       cur;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            tracking = 1'b0;
            prev_sel = 4'hF;
            continue;
         end
         check("one_hot", {31'd0, ($countones(~bus.digit_select) <= 1)}, 32'h1);
         if (bus.digit_select == 4'hF)
            check("blank_segments", {25'd0, bus.segments}, 32'h7F);
         if (bus.digit_select != 4'hF && prev_sel == 4'hF) begin
            if (exp_q.size() > 0) begin
               cur = exp_q.pop_front();
               check("digit_select", {28'd0, bus.digit_select}, {28'd0, cur.sel});
               check("segments", {25'd0, bus.segments}, {25'd0, cur.seg});
               check("dp", {31'd0, bus.dp}, {31'd0, cur.dp});
               tracking  = 1'b1;
               dwell_len = 1;
            end
         end else if (bus.digit_select != 4'hF && tracking) begin
            dwell_len++;
         end else if (bus.digit_select == 4'hF && prev_sel != 4'hF && tracking) begin
            check("dwell_len", dwell_len, 6);
            tracking = 1'b0;
         end
         prev_sel = bus.digit_select;
      end
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int at;
   int last_fd;
   int rel;
   int n;
   bit seen;

   initial begin
      rst                    = 1'b1;
      bus.number             = 16'h0000;
      bus.dp_enable          = 1'b0;
      bus.blank_leading_zero = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_pins("reset");

      // First frame after reset shows the reset snapshot "0000".
      push(4'hE, 7'h40, 1'b1);
      push(4'hD, 7'h40, 1'b1);
      push(4'hB, 7'h40, 1'b1);
      push(4'h7, 7'h40, 1'b1);
      bus.number = 16'h1234;
      rst        = 1'b0;
      rel        = cyc;
      wait_frame(at);
      check("first_frame_done", at - rel, 32);
      last_fd = at;

      check("queue_drained_0000", exp_q.size(), 0);
      push(4'hE, 7'h19, 1'b1);
      push(4'hD, 7'h30, 1'b1);
      push(4'hB, 7'h24, 1'b1);
      push(4'h7, 7'h79, 1'b1);
      @(negedge clk);
      bus.number = 16'h0959;

      wait_frame(at);
      check("frame_period_1234", at - last_fd, 32);
      last_fd = at;
      check("queue_drained_1234", exp_q.size(), 0);
      push(4'hE, 7'h10, 1'b1);
      push(4'hD, 7'h12, 1'b1);
      push(4'hB, 7'h10, 1'b1);
      push(4'h7, 7'h40, 1'b1);
      @(negedge clk);
      repeat (10) @(negedge clk);
      bus.number = 16'h1000;

      wait_frame(at);
      check("frame_period_0959", at - last_fd, 32);
      last_fd = at;
      check("queue_drained_0959", exp_q.size(), 0);
      push(4'hE, 7'h40, 1'b1);
      push(4'hD, 7'h40, 1'b1);
      push(4'hB, 7'h40, 1'b1);
      push(4'h7, 7'h79, 1'b1);
      @(negedge clk);
      bus.number = 16'h00A0;

      wait_frame(at);
      check("frame_period_1000", at - last_fd, 32);
      last_fd = at;
      check("queue_drained_1000", exp_q.size(), 0);
      push(4'hE, 7'h40, 1'b1);
      push(4'hD, 7'h3F, 1'b1);
      push(4'hB, 7'h40, 1'b1);
      push(4'h7, 7'h40, 1'b1);
      @(negedge clk);
      bus.number = 16'h0459;

      wait_frame(at);
      check("frame_period_00A0", at - last_fd, 32);
      last_fd = at;
      check("queue_drained_00A0", exp_q.size(), 0);
      @(negedge clk);
      bus.blank_leading_zero = 1'b1;
      bus.dp_enable          = 1'b1;
      push(4'hE, 7'h10, 1'b1);
      push(4'hD, 7'h12, 1'b1);
      push(4'hB, 7'h19, 1'b0);
      push(4'h7, 7'h7F, 1'b1);

      wait_frame(at);
      check("frame_period_0459", at - last_fd, 32);
      last_fd = at;
      check("queue_drained_0459", exp_q.size(), 0);

      // Reach i=2, p=5 (21 edges after the snapshot edge), then reset for one edge.
      @(negedge clk);
      repeat (21) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_pins("reset_mid_scan");
      push(4'hE, 7'h40, 1'b1);
      push(4'hD, 7'h40, 1'b1);
      push(4'hB, 7'h40, 1'b0);
      push(4'h7, 7'h7F, 1'b1);
      rst  = 1'b0;
      rel  = cyc;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(posedge clk);
         #1;
         n = cyc - rel;
         if (n <= 2) check("restart_blank", {28'd0, bus.digit_select}, 32'hF);
         if (n == 3) check("restart_digit0", {28'd0, bus.digit_select}, 32'hE);
         if (bus.frame_done) seen = 1'b1;
      end
      check("restart_frame_done", {31'd0, seen}, 32'h1);
      check("restart_frame_time", n, 32);
      repeat (8) @(negedge clk);
      check("queue_drained_final", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
